// File: rtl/mdu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mdu_ctrl_pkg
//   Shared definitions for the multiply/divide unit: MDU opcode encodings,
//   controller state encoding, default latencies and small opcode-class
//   helpers used by the controller, the decoder and the stall logic.
//
//   Build option: MDU_MADD_EN (when defined, MADD/MADDU count as accepted
//   arithmetic ops; otherwise they decode as unknown).
// ---------------------------------------------------------------------------
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MADD  = 4'd4,
    OP_MADDU = 4'd5,
    OP_MTHI  = 4'd6,
    OP_MTLO  = 4'd7
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Ops that open a busy window when issued with start.
  function automatic logic op_is_arith(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: ok = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU:                  ok = 1'b1;
`endif
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// ---------------------------------------------------------------------------
// mdu_calc
//   Combinational result datapath for the MDU. Produces the 64-bit {hi,lo}
//   value that the controller commits on the completion edge.
//
//   Build option: MDU_MADD_EN enables the MADD/MADDU accumulate paths.
//
// Ports
//   op      in   4   latched MDU opcode
//   a       in   32  latched operand A (rs)
//   b       in   32  latched operand B (rt)
//   hi      in   32  current HI (accumulate source)
//   lo      in   32  current LO (accumulate source)
//   res     out  64  {hi,lo} to write
//   res_we  out  1   commit enable (low for divide-by-zero and unknown ops)
// ---------------------------------------------------------------------------
module mdu_calc
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        res_we
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_signed;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        quot;
  logic [31:0]        rem;

`ifndef MDU_MADD_EN
  // HI/LO only feed the accumulate path; keep them visibly consumed.
  logic unused_acc;
  assign unused_acc = ^{hi, lo};
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    res    = '0;
    res_we = 1'b0;

    a_sx   = {{32{a[31]}}, a};
    b_sx   = {{32{b[31]}}, b};
    prod_s = a_sx * b_sx;
    prod_u = {32'b0, a} * {32'b0, b};

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. |-2^31| stays 0x80000000, which
    // is the correct unsigned magnitude.
    div_signed = (op == OP_DIV);
    a_mag = (div_signed && a[31]) ? (~a + 32'd1) : a;
    b_mag = (div_signed && b[31]) ? (~b + 32'd1) : b;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    quot  = (div_signed && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    rem   = (div_signed && a[31])           ? (~r_mag + 32'd1) : r_mag;

    case (op)
      OP_MULT:  begin res = prod_s;      res_we = 1'b1; end
      OP_MULTU: begin res = prod_u;      res_we = 1'b1; end
      OP_DIV,
      OP_DIVU:  begin res = {rem, quot}; res_we = |b;   end
`ifdef MDU_MADD_EN
      OP_MADD:  begin res = {hi, lo} + prod_s; res_we = 1'b1; end
      OP_MADDU: begin res = {hi, lo} + prod_u; res_we = 1'b1; end
`endif
      default:  begin res = '0;          res_we = 1'b0; end
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl
//   Multiply/divide unit controller for the 5-stage MIPS pipeline. Accepts
//   MDU ops issued from EX, runs a fixed-latency busy window, owns HI/LO and
//   raises the D-stage stall when an MDU-dependent instruction meets a busy
//   (or just-starting) unit.
//
//   Build option: MDU_MADD_EN enables MADD/MADDU (MULT_CYCLES latency,
//   64-bit wrap-around accumulate into {hi,lo}).
//
// Parameters
//   MULT_CYCLES  busy cycles for MULT/MULTU/MADD/MADDU (>=1)
//   DIV_CYCLES   busy cycles for DIV/DIVU (>=1)
//
// Ports
//   clk       in   1   system clock, rising edge
//   reset     in   1   synchronous, active-high
//   start     in   1   EX holds an arithmetic MDU op this cycle
//   op        in   4   MDU opcode, valid with start or mt_we
//   mt_we     in   1   EX holds MTHI/MTLO this cycle
//   rs_val    in   32  forwarded GPR[rs] (operand A / MT data)
//   rt_val    in   32  forwarded GPR[rt] (operand B)
//   md_use_d  in   1   D holds any MDU instruction
//   busy      out  1   operation in progress
//   hi        out  32  HI register
//   lo        out  32  LO register
//   stall     out  1   md_use_d & (start | busy)
// ---------------------------------------------------------------------------
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic        mt_we,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [3:0]        op_q,    op_d;
  logic [31:0]       a_q,     a_d;
  logic [31:0]       b_q,     b_d;
  logic [31:0]       hi_q,    hi_d;
  logic [31:0]       lo_q,    lo_d;

  logic [63:0]       calc_res;
  logic              calc_we;

  mdu_calc u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .res    (calc_res),
    .res_we (calc_we)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        // start owns the single EX slot, so a simultaneous mt_we is dropped.
        if (start) begin
          if (op_is_arith(op)) begin
            op_d    = op;
            a_d     = rs_val;
            b_d     = rt_val;
            cnt_d   = op_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d = ST_RUN;
          end
        end else if (mt_we) begin
          if (op == OP_MTHI) hi_d = rs_val;
          else if (op == OP_MTLO) lo_d = rs_val;
        end
      end

      ST_RUN: begin
        // Operand latches are stable for the whole window, so the result
        // (including the accumulate source) is read on the last edge.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (calc_we) {hi_d, lo_d} = calc_res;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = md_use_d & (start | busy);

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl
//   Self-checking bench for mdu_ctrl. A timestamp-based behavioural model
//   (completion edge = start edge + latency, results from plain 64-bit
//   arithmetic) is compared against busy/hi/lo/stall on every falling edge;
//   directed sequences add hand-computed literal expectations.
//   Build option: MDU_MADD_EN selects the MADD expectations.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic        mt_we;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_d;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;

  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .mt_we    (mt_we),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_d (md_use_d),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned edge_no = 0;
  bit          m_active = 1'b0;
  int unsigned m_done   = 0;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  function automatic bit model_accepts(input logic [3:0] o);
    if (o == OP_MULT || o == OP_MULTU || o == OP_DIV || o == OP_DIVU) return 1'b1;
`ifdef MDU_MADD_EN
    if (o == OP_MADD || o == OP_MADDU) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [63:0] model_result(input logic [3:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
    longint sa, sb, ua, ub, q, r, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      OP_MULT:  p = sa * sb;
      OP_MULTU: p = ua * ub;
      OP_DIV: begin
        if (b == 0) return {h, l};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      OP_DIVU: begin
        if (b == 0) return {h, l};
        q = ua / ub; r = ua % ub;
        return {r[31:0], q[31:0]};
      end
      OP_MADD:  p = longint'({h, l}) + sa * sb;
      OP_MADDU: p = longint'({h, l}) + ua * ub;
      default:  return {h, l};
    endcase
    return p;
  endfunction

  always @(posedge clk) begin
    edge_no++;
    if (reset) begin
      m_active = 1'b0;
      m_hi = '0;
      m_lo = '0;
    end else if (m_active) begin
      if (edge_no == m_done) begin
        {m_hi, m_lo} = model_result(m_op, m_a, m_b, m_hi, m_lo);
        m_active = 1'b0;
      end
    end else if (start) begin
      if (model_accepts(op)) begin
        m_active = 1'b1;
        m_done   = edge_no + ((op == OP_DIV || op == OP_DIVU) ? DC : MC);
        m_op = op; m_a = rs_val; m_b = rt_val;
      end
    end else if (mt_we) begin
      if (op == OP_MTHI) m_hi = rs_val;
      else if (op == OP_MTLO) m_lo = rs_val;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy",  busy,  m_active);
      check("model_hi",    hi,    m_hi);
      check("model_lo",    lo,    m_lo);
      check("model_stall", stall, md_use_d & (start | m_active));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int exp_busy, input string name);
    int n;
    tick();
    op = o; rs_val = a; rt_val = b; start = 1'b1; md_use_d = 1'b1;
    @(negedge clk);
    check({name, "_stall_start"}, stall, 1);
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check({name, "_busy_cycles"}, n, exp_busy);
    check({name, "_stall_drop"}, stall, 0);
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] d);
    tick();
    op = o; rs_val = d; mt_we = 1'b1; md_use_d = 1'b0;
    tick();
    mt_we = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    reset = 1'b1; start = 1'b0; op = '0; mt_we = 1'b0;
    rs_val = '0; rt_val = '0; md_use_d = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_hi",   hi,   0);
    check("reset_lo",   lo,   0);

    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, MC, "mult_neg3x7");
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, DC, "div_neg7by2");
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    run_op(OP_DIVU, 32'd7, 32'd0, DC, "divu_by0");
    check("divu0_hi", hi, 32'hFFFF_FFFF);
    check("divu0_lo", lo, 32'hFFFF_FFFD);

    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, DC, "div_7byneg2");
    check("div2_lo", lo, 32'hFFFF_FFFD);
    check("div2_hi", hi, 32'd1);

    mt(OP_MTHI, 32'h1234);
    check("mthi_hi", hi, 32'h1234);

    // MTLO issued in the middle of a MULT window must be ignored.
    tick();
    op = OP_MULT; rs_val = 32'd5; rt_val = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    op = OP_MTLO; rs_val = 32'hDEAD; mt_we = 1'b1;
    tick();
    mt_we = 1'b0;
    @(negedge clk);
    check("mtlo_busy_lo", lo, 32'hFFFF_FFFD);
    n = 0;
    while (busy && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("mult5x6_done", busy, 0);
    check("mult5x6_hi", hi, 32'd0);
    check("mult5x6_lo", lo, 32'd30);

    // Reset during the third busy cycle of a DIV discards the result.
    tick();
    op = OP_DIV; rs_val = 32'd100; rt_val = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_hi",   hi,   0);
    check("abort_lo",   lo,   0);
    repeat (DC + 2) tick();
    check("abort_lo_late", lo, 0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, MC, "multu_max2");
    check("multu_hi", hi, 32'd1);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(4'hF, 32'd1, 32'd1, 0, "unknown_op");
    check("unknown_hi", hi, 32'd1);
    check("unknown_lo", lo, 32'hFFFF_FFFE);

    run_op(OP_MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFB, MC, "mult_neg4xneg5");
    check("mult_nn_hi", hi, 32'd0);
    check("mult_nn_lo", lo, 32'd20);

`ifdef MDU_MADD_EN
    mt(OP_MTHI, 32'd0);
    mt(OP_MTLO, 32'hFFFF_FFFF);
    run_op(OP_MADDU, 32'd1, 32'd1, MC, "maddu_1x1");
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);
`else
    run_op(OP_MADDU, 32'd1, 32'd1, 0, "maddu_off");
    check("maddu_off_hi", hi, 32'd0);
    check("maddu_off_lo", lo, 32'd20);
`endif

    tick();
    md_use_d = 1'b0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
